// File: rtl/fir_dsp_pkg.sv
// FIR program decode shared definitions: opcodes, instruction field positions, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_dsp_pkg;

  // Default geometry of the program RAM and datapath addressing
  localparam int AW_DEF  = 8;
  localparam int IW_DEF  = 20;
  localparam int DAW_DEF = 8;

  // Instruction field positions: [19:16] opcode, [15:8] high operand byte, [7:0] low operand byte
  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int OPH_HI = 15;
  localparam int OPH_LO = 8;
  localparam int OPL_HI = 7;
  localparam int OPL_LO = 0;

  // Opcodes; any other value executes as a NOP
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOOP = 4'd1;
  localparam logic [3:0] OP_MAC  = 4'd2;
  localparam logic [3:0] OP_CLR  = 4'd3;
  localparam logic [3:0] OP_OUT  = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Loop one-shot: ARM may fire loop_we, SPENT suppresses it while the same LOOP word is held
  typedef enum logic {
    LS_ARM   = 1'b0,
    LS_SPENT = 1'b1
  } loop_state_t;

  // Opcode field of an instruction word
  function automatic logic [3:0] get_opcode(input logic [IW_DEF-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instr_decode_prog_ram.sv
// FIR program RAM: asynchronous read, synchronous write, depth 2**AW, contents not reset.
// Latency: read is combinational; a write becomes visible on the cycle after the write edge.
// Backpressure: none; writes are accepted every cycle i_we is high.
module prog_ram
  import fir_dsp_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_raddr,
  output logic [IW-1:0] o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata
);

  logic [IW-1:0] r_mem [2**AW];

  // Load-mode write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_decode.sv
// FIR fetch/decode: reads the program word at addr, returns loop setup to the sequencer, drives MAC control.
// Latency: loop_we/loop_iter/loop_size combinational; execute outputs registered, 1 cycle after the word.
// Backpressure: none; prog_we (load mode) or halted suppress loop_we and all execute pulses.
module instr_decode
  import fir_dsp_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int IW  = IW_DEF,
  parameter int DAW = DAW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    addr,
  input  logic           prog_we,
  input  logic [AW-1:0]  prog_waddr,
  input  logic [IW-1:0]  prog_wdata,
  output logic           loop_we,
  output logic [7:0]     loop_iter,
  output logic [7:0]     loop_size,
  output logic           mac_en,
  output logic           acc_clr,
  output logic [DAW-1:0] coef_addr,
  output logic [DAW-1:0] x_addr,
  output logic           y_we,
  output logic           halted
);

  logic [IW-1:0]  w_word;
  logic [3:0]     w_opcode;
  logic [7:0]     w_op_hi;
  logic [7:0]     w_op_lo;
  logic           w_exec_ok;
  logic           w_loop_hit;
  logic           w_armed;
  logic           w_loop_we;
  loop_state_t    w_state_nxt;
  logic [15:0]    w_loop_addr_nxt;

  loop_state_t    r_state;
  logic [15:0]    r_loop_addr;
  logic           r_mac_en;
  logic           r_acc_clr;
  logic           r_y_we;
  logic [DAW-1:0] r_coef_addr;
  logic [DAW-1:0] r_x_addr;
  logic           r_halted;

  prog_ram #(
    .AW (AW),
    .IW (IW)
  ) u_prog_ram (
    .i_clk   (clk),
    .i_raddr (addr[AW-1:0]),
    .o_rdata (w_word),
    .i_we    (prog_we),
    .i_waddr (prog_waddr),
    .i_wdata (prog_wdata)
  );

  assign w_opcode  = get_opcode(w_word);
  assign w_op_hi   = w_word[OPH_HI:OPH_LO];
  assign w_op_lo   = w_word[OPL_HI:OPL_LO];
  // Words fetched during program load or after HALT are never executed
  assign w_exec_ok = !prog_we && !r_halted;

  // Loop one-shot: fire once per visit to a LOOP word; any change of addr re-arms immediately
  always_comb begin
    w_state_nxt     = r_state;
    w_loop_addr_nxt = r_loop_addr;
    w_loop_hit      = (w_opcode == OP_LOOP) && w_exec_ok;
    w_armed         = (r_state == LS_ARM) || (addr != r_loop_addr);
    w_loop_we       = w_loop_hit && w_armed;
    if (!prog_we) begin
      if (w_loop_we) begin
        w_state_nxt     = LS_SPENT;
        w_loop_addr_nxt = addr;
      end else if (w_armed) begin
        w_state_nxt     = LS_ARM;
      end
    end
  end

  // One-shot state and the address of the LOOP word it has already served
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= LS_ARM;
      r_loop_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_loop_addr <= w_loop_addr_nxt;
    end
  end

  // Registered execute control and sticky halt; address outputs only move on MAC
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mac_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_y_we      <= 1'b0;
      r_coef_addr <= '0;
      r_x_addr    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_mac_en  <= w_exec_ok && (w_opcode == OP_MAC);
      r_acc_clr <= w_exec_ok && (w_opcode == OP_CLR);
      r_y_we    <= w_exec_ok && (w_opcode == OP_OUT);
      if (w_exec_ok && (w_opcode == OP_MAC)) begin
        r_coef_addr <= DAW'(w_op_hi);
        r_x_addr    <= DAW'(w_op_lo);
      end
      if (w_exec_ok && (w_opcode == OP_HALT)) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign loop_we   = w_loop_we;
  assign loop_iter = w_op_hi;
  assign loop_size = w_op_lo;
  assign mac_en    = r_mac_en;
  assign acc_clr   = r_acc_clr;
  assign y_we      = r_y_we;
  assign coef_addr = r_coef_addr;
  assign x_addr    = r_x_addr;
  assign halted    = r_halted;

endmodule
